tuser_merge_fifo: RTL and testbench
===================================

Name: tuser_merge_fifo

Overview:
Parametrised successor of the tuser output stage in the SDNet Paxos datapath. It joins a packet AXI4-Stream with a per-packet metadata tuple and emits the packet with the tuple on tuser. Unlike the single-tuple FSM, it buffers up to FIFO_DEPTH tuples ahead of their packets. It has a tuple ready handshake, a registered output stage, and selectable tuser-on-every-beat or tuser-on-first-beat mode. It sits between the SDNet engine outputs and the downstream output queues.

Parameters:
DATA_WIDTH, 256, packet data width in bits; multiple of 8.
TUPLE_WIDTH, 128, tuple/tuser width in bits.
FIFO_DEPTH, 4, tuple FIFO entries; power of 2, >= 2.
TUSER_ALL_BEATS, 1, 1 = tuple on every beat; 0 = tuple on first beat only, zeros on other beats.

Ports:
tmrg_aclk  in  1  clock
tmrg_arst_n  in  1  reset, asynchronous, active-low
tmrg_avalid  in  1  packet beat valid
tmrg_aready  out  1  packet beat ready
tmrg_adata  in  DATA_WIDTH  packet data
tmrg_akeep  in  DATA_WIDTH/8  byte enables
tmrg_atlast  in  1  last beat of packet
tmrg_tvalid  in  1  tuple valid
tmrg_tready  out  1  tuple ready
tmrg_tdata  in  TUPLE_WIDTH  tuple
tmrg_bvalid  out  1  output beat valid
tmrg_bready  in  1  downstream ready
tmrg_bdata  out  DATA_WIDTH  output data
tmrg_bkeep  out  DATA_WIDTH/8  output keep
tmrg_btlast  out  1  output last
tmrg_btuser  out  TUPLE_WIDTH  tuple attached to beat
tmrg_tuple_level  out  clog2(FIFO_DEPTH)+1  tuples currently buffered
tmrg_pkt_cnt  out  32  packets completed on output
dbg_state  out  2  FSM state encoding

Behaviour:
- Reset (tmrg_arst_n=0, async assert, sync deassert usage): FIFO emptied, state WAIT_TUPLE. Outputs: bvalid=0, bdata=0, bkeep=0, btlast=0, btuser=0, aready=0, tready=1, tuple_level=0, pkt_cnt=0, dbg_state=0.
- Reset mid-packet discards the partial packet and all buffered tuples. There is no recovery of the partial packet.
- Tuple FIFO:
  - Push on tvalid&tready. tready = (level < FIFO_DEPTH), derived from registered level.
  - When full, tready=0 even if a pop occurs the same cycle; there is no bypass.
  - Pop occurs on acceptance of the input beat with atlast=1.
  - Push and pop in the same cycle leave level unchanged.
  - A tuple pushed into an empty FIFO is usable the next cycle; there is no same-cycle fall-through.
- Output slot free = !bvalid | bready.
- tmrg_aready = slot free & (state != WAIT_TUPLE). An input beat is accepted on avalid&aready.
- FSM states: WAIT_TUPLE=0, SOP=1, BODY=2.
  - WAIT_TUPLE: FIFO empty, no beats accepted. Go to SOP when level != 0.
  - SOP: FIFO head is the tuple for the next packet.
    - Beat accepted with atlast=1: pop. Next state is SOP if level after pop > 0, else WAIT_TUPLE.
    - Beat accepted with atlast=0: go to BODY.
  - BODY: on accepted beat with atlast=1, pop. Next state is SOP/WAIT_TUPLE by the same rule; otherwise stay in BODY.
- Output register:
  - Accepted beat loads bdata, bkeep, btlast, and btuser, and sets bvalid the next cycle. Latency is 1 cycle.
  - btuser = FIFO head when TUSER_ALL_BEATS=1, or when the beat is the first beat (state SOP). Otherwise btuser=0.
  - While bvalid&!bready, all b* outputs hold stable.
  - bvalid clears on bready when no new beat is accepted that cycle.
  - Back-to-back beats give full throughput when bready stays 1.
- tmrg_pkt_cnt increments on bvalid&bready&btlast and wraps 0xFFFFFFFF -> 0.
- avalid without a buffered tuple stalls (aready=0). No beat or tuple is ever dropped.

Test Plan:
- Reset, push tuple 44444, then a 3-beat packet with adata=22222, akeep=33333 and bready=1 -> aready first high the cycle after the push; 3 output beats each btuser=44444; btlast on beat 3; pkt_cnt=1; tuple_level returns to 0.
- Packet presented before any tuple -> aready=0 and bvalid=0 for 10 cycles. Then push tuple 7 -> first beat appears 2 cycles after the push, btuser=7.
- Push 5 tuples (1..5) with FIFO_DEPTH=4 and no packets -> tready drops after the 4th; tuple_level=4; the 5th is held. Then four 1-beat packets -> btuser sequence 1,2,3,4; the 5th tuple is then accepted.
- TUSER_ALL_BEATS=0, tuple 9, 4-beat packet -> btuser=9 on beat 1 and 0 on beats 2-4.
- Toggle bready 1/0 every cycle during a 4-beat packet -> b* outputs stable while stalled; no beat lost or duplicated; beat order preserved.
- Assert tmrg_arst_n=0 after beat 2 of 4 with 2 tuples buffered -> bvalid=0, tuple_level=0, dbg_state=0 immediately. After release, a new tuple and packet pass normally with pkt_cnt=1.

Source files
------------

// File: rtl/tuser_merge_fifo.sv
// tuser_merge_fifo: joins a packet AXI4-Stream with per-packet tuples held in a small FIFO and drives the tuple on tuser.
// Latency: 1 cycle from input beat acceptance to output beat; a pushed tuple is usable the cycle after its push.
// Backpressure: aready drops while the output register is held (!bready) or no tuple is buffered; tready drops when the tuple FIFO is full.
//
// Ports:
//   tmrg_aclk / tmrg_arst_n                      clock, async active-low reset
//   tmrg_avalid/aready/adata/akeep/atlast        packet input stream
//   tmrg_tvalid/tready/tdata                     tuple input
//   tmrg_bvalid/bready/bdata/bkeep/btlast/btuser merged output stream (registered)
//   tmrg_tuple_level, tmrg_pkt_cnt, dbg_state    status / debug

// Tuple FIFO: registered level, head always visible, no fall-through.
// Caller never pushes when full nor pops when empty.
module tuser_merge_fifo_tq #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push_vld,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_dat,
   output logic [AW:0]      o_level,
   output logic             o_full
);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap naturally.
         if (i_push_vld) r_wptr <= r_wptr + AW'(1);
         if (i_pop)      r_rptr <= r_rptr + AW'(1);
         case ({i_push_vld, i_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push_vld) r_mem[r_wptr] <= i_push_dat;
   end

   assign o_head_dat = r_mem[r_rptr];
   assign o_level    = r_level;
   assign o_full     = (r_level == LW'(DEPTH));
endmodule

module tuser_merge_fifo #(
   parameter int DATA_WIDTH      = 256,
   parameter int TUPLE_WIDTH     = 128,
   parameter int FIFO_DEPTH      = 4,
   parameter int TUSER_ALL_BEATS = 1
) (
   input  logic                         tmrg_aclk,
   input  logic                         tmrg_arst_n,
   input  logic                         tmrg_avalid,
   output logic                         tmrg_aready,
   input  logic [DATA_WIDTH-1:0]        tmrg_adata,
   input  logic [DATA_WIDTH/8-1:0]      tmrg_akeep,
   input  logic                         tmrg_atlast,
   input  logic                         tmrg_tvalid,
   output logic                         tmrg_tready,
   input  logic [TUPLE_WIDTH-1:0]       tmrg_tdata,
   output logic                         tmrg_bvalid,
   input  logic                         tmrg_bready,
   output logic [DATA_WIDTH-1:0]        tmrg_bdata,
   output logic [DATA_WIDTH/8-1:0]      tmrg_bkeep,
   output logic                         tmrg_btlast,
   output logic [TUPLE_WIDTH-1:0]       tmrg_btuser,
   output logic [$clog2(FIFO_DEPTH):0]  tmrg_tuple_level,
   output logic [31:0]                  tmrg_pkt_cnt,
   output logic [1:0]                   dbg_state
);
   localparam int KW = DATA_WIDTH / 8;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {
      WAIT_TUPLE = 2'd0,
      SOP        = 2'd1,
      BODY       = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic                   r_bvalid;
   logic [DATA_WIDTH-1:0]  r_bdata;
   logic [KW-1:0]          r_bkeep;
   logic                   r_btlast;
   logic [TUPLE_WIDTH-1:0] r_btuser;
   logic [31:0]            r_pkt_cnt;

   logic                   w_full;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_slot_free;
   logic                   w_a_acc;
   logic [TUPLE_WIDTH-1:0] w_head;
   logic [TUPLE_WIDTH-1:0] w_tuser_sel;
   logic [LW-1:0]          w_level;
   logic [LW-1:0]          w_level_nxt;

   tuser_merge_fifo_tq #(
      .WIDTH (TUPLE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_tq (
      .i_clk      (tmrg_aclk),
      .i_rst_n    (tmrg_arst_n),
      .i_push_vld (w_push),
      .i_push_dat (tmrg_tdata),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_level    (w_level),
      .o_full     (w_full)
   );

   // tready comes from the registered level only: a pop in the same cycle
   // does not open a slot for a push while full.
   assign tmrg_tready = !w_full;
   assign w_push      = tmrg_tvalid & tmrg_tready;

   assign w_slot_free = !r_bvalid | tmrg_bready;
   assign tmrg_aready = w_slot_free & (r_state != WAIT_TUPLE);
   assign w_a_acc     = tmrg_avalid & tmrg_aready;
   assign w_pop       = w_a_acc & tmrg_atlast;
   assign w_level_nxt = w_level + LW'(w_push) - LW'(w_pop);

   assign w_tuser_sel = ((TUSER_ALL_BEATS != 0) || (r_state == SOP)) ? w_head : '0;

   always_ff @(posedge tmrg_aclk or negedge tmrg_arst_n) begin
      if (!tmrg_arst_n) begin
         r_state <= WAIT_TUPLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // WAIT_TUPLE is held exactly while the FIFO is empty, so a push is what
   // makes the level non-zero; the tuple is then in the head slot next cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_TUPLE: begin
            if (w_push) w_state_nxt = SOP;
         end
         SOP, BODY: begin
            if (w_a_acc) begin
               if (tmrg_atlast) begin
                  w_state_nxt = (w_level_nxt != '0) ? SOP : WAIT_TUPLE;
               end else begin
                  w_state_nxt = BODY;
               end
            end
         end
         default: w_state_nxt = WAIT_TUPLE;
      endcase
   end

   always_ff @(posedge tmrg_aclk or negedge tmrg_arst_n) begin
      if (!tmrg_arst_n) begin
         r_bvalid  <= 1'b0;
         r_bdata   <= '0;
         r_bkeep   <= '0;
         r_btlast  <= 1'b0;
         r_btuser  <= '0;
         r_pkt_cnt <= '0;
      end else begin
         if (w_a_acc) begin
            r_bvalid <= 1'b1;
            r_bdata  <= tmrg_adata;
            r_bkeep  <= tmrg_akeep;
            r_btlast <= tmrg_atlast;
            r_btuser <= w_tuser_sel;
         end else if (tmrg_bready) begin
            r_bvalid <= 1'b0;
         end
         if (r_bvalid & tmrg_bready & r_btlast) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
         end
      end
   end

   assign tmrg_bvalid      = r_bvalid;
   assign tmrg_bdata       = r_bdata;
   assign tmrg_bkeep       = r_bkeep;
   assign tmrg_btlast      = r_btlast;
   assign tmrg_btuser      = r_btuser;
   assign tmrg_pkt_cnt     = r_pkt_cnt;
   assign tmrg_tuple_level = w_level;
   assign dbg_state        = r_state;
endmodule

// File: tb/tb_tuser_merge_fifo.sv
// tb_tuser_merge_fifo: drives two instances (tuple on every beat / first beat only) with shared stimulus.
// Latency: checks every cycle against a queue-based reference model.
// Backpressure: random and toggling bready; tuple FIFO overflow attempts.
module tb_tuser_merge_fifo;
   localparam int DW    = 256;
   localparam int TW    = 128;
   localparam int DEPTH = 4;
   localparam int KW    = DW / 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          avalid = 1'b0;
   logic          atlast = 1'b0;
   logic          tvalid = 1'b0;
   logic          bready = 1'b0;
   logic [DW-1:0] adata  = '0;
   logic [KW-1:0] akeep  = '0;
   logic [TW-1:0] tdata  = '0;

   logic          aready, tready, bvalid, btlast;
   logic [DW-1:0] bdata;
   logic [KW-1:0] bkeep;
   logic [TW-1:0] btuser;
   logic [LW-1:0] level;
   logic [31:0]   pkt_cnt;
   logic [1:0]    dbg;

   logic          aready_z, tready_z, bvalid_z, btlast_z;
   logic [DW-1:0] bdata_z;
   logic [KW-1:0] bkeep_z;
   logic [TW-1:0] btuser_z;
   logic [LW-1:0] level_z;
   logic [31:0]   pkt_z;
   logic [1:0]    dbg_z;

   always #5 clk = ~clk;

   tuser_merge_fifo #(.DATA_WIDTH(DW), .TUPLE_WIDTH(TW), .FIFO_DEPTH(DEPTH), .TUSER_ALL_BEATS(1)) dut (
      .tmrg_aclk(clk), .tmrg_arst_n(rst_n),
      .tmrg_avalid(avalid), .tmrg_aready(aready), .tmrg_adata(adata), .tmrg_akeep(akeep), .tmrg_atlast(atlast),
      .tmrg_tvalid(tvalid), .tmrg_tready(tready), .tmrg_tdata(tdata),
      .tmrg_bvalid(bvalid), .tmrg_bready(bready), .tmrg_bdata(bdata), .tmrg_bkeep(bkeep),
      .tmrg_btlast(btlast), .tmrg_btuser(btuser),
      .tmrg_tuple_level(level), .tmrg_pkt_cnt(pkt_cnt), .dbg_state(dbg)
   );

   tuser_merge_fifo #(.DATA_WIDTH(DW), .TUPLE_WIDTH(TW), .FIFO_DEPTH(DEPTH), .TUSER_ALL_BEATS(0)) dut_first (
      .tmrg_aclk(clk), .tmrg_arst_n(rst_n),
      .tmrg_avalid(avalid), .tmrg_aready(aready_z), .tmrg_adata(adata), .tmrg_akeep(akeep), .tmrg_atlast(atlast),
      .tmrg_tvalid(tvalid), .tmrg_tready(tready_z), .tmrg_tdata(tdata),
      .tmrg_bvalid(bvalid_z), .tmrg_bready(bready), .tmrg_bdata(bdata_z), .tmrg_bkeep(bkeep_z),
      .tmrg_btlast(btlast_z), .tmrg_btuser(btuser_z),
      .tmrg_tuple_level(level_z), .tmrg_pkt_cnt(pkt_z), .dbg_state(dbg_z)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: queue of accepted tuples, one pending output beat,
   // a first-beat-of-packet flag and a packet counter.
   logic [TW-1:0] m_tq[$];
   bit            m_ovld  = 1'b0;
   logic [DW-1:0] m_dat   = '0;
   logic [KW-1:0] m_keep  = '0;
   bit            m_last  = 1'b0;
   logic [TW-1:0] m_u_all = '0;
   logic [TW-1:0] m_u_first = '0;
   bit            m_first = 1'b1;
   int unsigned   m_pkts  = 0;
   bit            acc_a   = 1'b0;
   bit            acc_t   = 1'b0;
   bit            tog_brdy = 1'b0;

   task automatic model_reset();
      m_tq.delete();
      m_ovld  = 1'b0;
      m_first = 1'b1;
      m_pkts  = 0;
      acc_a   = 1'b0;
      acc_t   = 1'b0;
   endtask

   task automatic model_update();
      bit a_rdy, t_rdy;
      if (!rst_n) begin
         model_reset();
         return;
      end
      a_rdy = (!m_ovld || bready) && (m_tq.size() != 0);
      t_rdy = m_tq.size() < DEPTH;
      acc_a = avalid && a_rdy;
      acc_t = tvalid && t_rdy;
      if (m_ovld && bready && m_last) m_pkts++;
      if (acc_a) begin
         m_dat     = adata;
         m_keep    = akeep;
         m_last    = atlast;
         m_u_all   = m_tq[0];
         m_u_first = m_first ? m_tq[0] : '0;
         m_ovld    = 1'b1;
         if (atlast) begin
            void'(m_tq.pop_front());
            m_first = 1'b1;
         end else begin
            m_first = 1'b0;
         end
      end else if (bready) begin
         m_ovld = 1'b0;
      end
      if (acc_t) m_tq.push_back(tdata);
   endtask

   task automatic check_outputs();
      bit exp_ardy;
      int exp_st;
      exp_ardy = (!m_ovld || bready) && (m_tq.size() != 0);
      exp_st   = (m_tq.size() == 0) ? 0 : (m_first ? 1 : 2);
      check("tready",    DW'(tready),   DW'(m_tq.size() < DEPTH));
      check("aready",    DW'(aready),   DW'(exp_ardy));
      check("aready_z",  DW'(aready_z), DW'(exp_ardy));
      check("bvalid",    DW'(bvalid),   DW'(m_ovld));
      check("bvalid_z",  DW'(bvalid_z), DW'(m_ovld));
      check("level",     DW'(level),    DW'(m_tq.size()));
      check("pkt_cnt",   DW'(pkt_cnt),  DW'(m_pkts));
      check("pkt_cnt_z", DW'(pkt_z),    DW'(m_pkts));
      check("dbg_state", DW'(dbg),      DW'(exp_st));
      if (m_ovld) begin
         check("bdata",    bdata,          m_dat);
         check("bkeep",    DW'(bkeep),     DW'(m_keep));
         check("btlast",   DW'(btlast),    DW'(m_last));
         check("btuser",   DW'(btuser),    DW'(m_u_all));
         check("bdata_z",  bdata_z,        m_dat);
         check("btuser_z", DW'(btuser_z),  DW'(m_u_first));
      end
   endtask

   task automatic check_reset();
      check("rst_bvalid", DW'(bvalid),  DW'(0));
      check("rst_bdata",  bdata,        DW'(0));
      check("rst_bkeep",  DW'(bkeep),   DW'(0));
      check("rst_btlast", DW'(btlast),  DW'(0));
      check("rst_btuser", DW'(btuser),  DW'(0));
      check("rst_aready", DW'(aready),  DW'(0));
      check("rst_tready", DW'(tready),  DW'(1));
      check("rst_level",  DW'(level),   DW'(0));
      check("rst_pkt",    DW'(pkt_cnt), DW'(0));
      check("rst_dbg",    DW'(dbg),     DW'(0));
      check("rst_bvalid_z", DW'(bvalid_z), DW'(0));
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_outputs();
      if (acc_t) tvalid = 1'b0;
      if (acc_a) avalid = 1'b0;
      if (tog_brdy) bready = ~bready;
   endtask

   task automatic push_tuple(input logic [TW-1:0] td);
      tvalid = 1'b1;
      tdata  = td;
      for (int i = 0; i < 50; i++) begin
         step();
         if (acc_t) break;
      end
      check("tuple_accept", DW'(acc_t), DW'(1));
      tvalid = 1'b0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last);
      avalid = 1'b1;
      adata  = d;
      akeep  = k;
      atlast = last;
      for (int i = 0; i < 50; i++) begin
         step();
         if (acc_a) break;
      end
      check("beat_accept", DW'(acc_a), DW'(1));
      avalid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_reset();
      rst_n = 1'b1;
      step();

      // Basic packet: tuple 44444, 3 beats.
      bready = 1'b1;
      push_tuple(TW'(44444));
      check("aready_after_push", DW'(aready), DW'(1));
      for (int i = 0; i < 3; i++) send_beat(DW'(22222), KW'(33333), i == 2);
      repeat (3) step();
      check("s1_pkt_cnt", DW'(pkt_cnt), DW'(1));
      check("s1_level",   DW'(level),   DW'(0));

      // Packet before tuple stalls; tuple 7 releases it two cycles later.
      avalid = 1'b1; adata = DW'(77); akeep = '1; atlast = 1'b1;
      repeat (10) step();
      check("s2_stall_bvalid", DW'(bvalid), DW'(0));
      push_tuple(TW'(7));
      step();
      check("s2_bvalid", DW'(bvalid), DW'(1));
      check("s2_btuser", DW'(btuser), DW'(7));
      avalid = 1'b0;
      repeat (2) step();

      // Overfill the tuple FIFO, then drain with four 1-beat packets.
      for (int i = 1; i <= 4; i++) push_tuple(TW'(i));
      tvalid = 1'b1; tdata = TW'(5);
      repeat (4) step();
      check("s3_tready_full", DW'(tready), DW'(0));
      check("s3_level_full",  DW'(level),  DW'(4));
      for (int i = 0; i < 4; i++) send_beat({8{$urandom}}, KW'($urandom), 1'b1);
      repeat (3) step();
      check("s3_level_after", DW'(level), DW'(1));
      send_beat({8{$urandom}}, '1, 1'b1);

      // Tuple 9 with a 4-beat packet (first-beat-only checked on the second instance).
      push_tuple(TW'(9));
      for (int i = 0; i < 4; i++) send_beat({8{$urandom}}, KW'($urandom), i == 3);
      repeat (2) step();

      // bready toggling every cycle during a 4-beat packet.
      push_tuple(TW'(11));
      tog_brdy = 1'b1;
      for (int i = 0; i < 4; i++) send_beat({8{$urandom}}, KW'($urandom), i == 3);
      repeat (6) step();
      tog_brdy = 1'b0;
      bready = 1'b1;
      step();

      // Reset mid-packet with two tuples buffered.
      push_tuple(TW'(21));
      push_tuple(TW'(22));
      send_beat({8{$urandom}}, '1, 1'b0);
      send_beat({8{$urandom}}, '1, 1'b0);
      check("s6_level_pre", DW'(level), DW'(2));
      rst_n = 1'b0;
      #1;
      check("s6_bvalid", DW'(bvalid), DW'(0));
      check("s6_level",  DW'(level),  DW'(0));
      check("s6_dbg",    DW'(dbg),    DW'(0));
      model_reset();
      repeat (2) step();
      rst_n = 1'b1;
      step();
      push_tuple(TW'(23));
      send_beat({8{$urandom}}, '1, 1'b0);
      send_beat({8{$urandom}}, '1, 1'b1);
      repeat (3) step();
      check("s6_pkt_cnt", DW'(pkt_cnt), DW'(1));

      // Randomized traffic with varying handshake densities.
      for (int seg = 0; seg < 4; seg++) begin
         int pa, pt, pb;
         pa = $urandom_range(20, 95);
         pt = $urandom_range(10, 90);
         pb = $urandom_range(20, 100);
         for (int c = 0; c < 800; c++) begin
            avalid = ($urandom_range(0, 99) < pa);
            adata  = {8{$urandom}};
            akeep  = KW'($urandom);
            atlast = ($urandom_range(0, 2) == 0);
            tvalid = ($urandom_range(0, 99) < pt);
            tdata  = {4{$urandom}};
            bready = ($urandom_range(0, 99) < pb);
            step();
         end
      end
      avalid = 1'b0;
      tvalid = 1'b0;
      bready = 1'b1;
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
